// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM state encoding and burst-mode constants for the RAM
// stream controller and its read-side skid buffer.
package ram_ctrl_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 24;

    localparam logic MODE_WR = 1'b0;
    localparam logic MODE_RD = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        DRAIN = 3'd3,
        FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry valid/ready skid FIFO holding RAM read data until the consumer
// takes it; the head word stays stable while the consumer stalls.
module ram_rd_skid #(
    parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic              pop;

    always_comb begin
        pop     = (count_q != 2'd0) && m_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop && push) begin
                    head_d = push_data;
                end else if (pop) begin
                    count_d = 2'd0;
                end else if (push) begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end
            end
            default: begin
                // Full: the tail moves up only when the head is consumed.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = push_data;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign m_valid = (count_q != 2'd0);
    assign m_data  = head_q;
    assign count   = count_q;

endmodule

// File: rtl/ram_stream_ctrl.sv
// Burst engine in front of the single-port RAM: write mode registers stream
// handshakes onto the RAM pins, read mode issues reads into a skid buffer.
module ram_stream_ctrl #(
    parameter int unsigned ADDR_W = ram_ctrl_pkg::ADDR_W,
    parameter int unsigned DATA_W = ram_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_re,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    import ram_ctrl_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_we_q, ram_we_d;
    logic              rd_out_q, rd_out_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [1:0]        skid_cnt;
    logic              hs, pop, rd_issue;
    logic [1:0]        occ;

    ram_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_out_q),
        .push_data (ram_dout),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .count     (skid_cnt)
    );

    assign s_ready = (state_q == WR);
    assign hs      = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

    // The word leaving the skid this cycle frees its slot, so a new read may
    // issue alongside a pop; this keeps one word per cycle with m_ready high.
    assign occ      = skid_cnt + {1'b0, rd_out_q} - {1'b0, pop};
    assign rd_issue = (state_q == RD) && (occ < 2'd2);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        rd_out_d   = rd_issue;
        done_d     = (state_q == FIN);
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = len_m1;
                    cnt_d   = '0;
                    state_d = (mode == MODE_RD) ? RD : WR;
                end
            end
            WR: begin
                if (hs) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = base_q + cnt_q;
                    ram_din_d  = s_data;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == len_q) state_d = FIN;
                end
            end
            RD: begin
                if (rd_issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((skid_cnt == 2'd0) && !rd_out_q) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Busy stays up through the done cycle and drops the cycle after.
        busy_d = (state_d != IDLE) || (state_q == FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            rd_out_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            rd_out_q   <= rd_out_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_we   = ram_we_q;
    assign ram_re   = rd_issue;
    assign ram_addr = rd_issue ? (base_q + cnt_q) : ram_addr_q;
    assign ram_din  = ram_din_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Directed bench for ram_stream_ctrl with a behavioural 64K x 24 RAM model.
module tb_ram_stream_ctrl;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] len_m1 = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          busy, done;
    logic [AW-1:0] ram_addr;
    logic          ram_we, ram_re;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;

    logic [DW-1:0] mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    logic [AW-1:0] we_addr_log[$];
    logic [DW-1:0] we_data_log[$];
    int            we_cyc_log[$];
    logic [AW-1:0] re_addr_log[$];
    int            re_cyc_log[$];
    int            mv_cyc_log[$];
    logic [DW-1:0] rd_log[$];
    int            hs_cyc[$];
    int            done_cnt = 0, done_cyc = 0, both_cnt = 0, stall_err = 0;
    int            re_total = 0, pop_total = 0, max_infl = 0;
    logic          prev_stall = 1'b0, prev_mv = 1'b0;
    logic [DW-1:0] prev_mdata = '0;

    ram_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .base_addr(base_addr), .len_m1(len_m1),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (ram_we) begin
            we_addr_log.push_back(ram_addr);
            we_data_log.push_back(ram_din);
            we_cyc_log.push_back(cyc_n);
        end
        if (ram_re) begin
            re_addr_log.push_back(ram_addr);
            re_cyc_log.push_back(cyc_n);
            re_total++;
        end
        if (ram_we && ram_re) both_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        if (m_valid && !prev_mv) mv_cyc_log.push_back(cyc_n);
        if (prev_stall && (m_data !== prev_mdata)) stall_err++;
        if (m_valid && m_ready) begin
            rd_log.push_back(m_data);
            pop_total++;
        end
        if (re_total - pop_total > max_infl) max_infl = re_total - pop_total;
        prev_stall = m_valid && !m_ready && !rst;
        prev_mv    = m_valid;
        prev_mdata = m_data;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [AW-1:0] b, input logic [AW-1:0] l,
                               input logic [DW-1:0] d[$], input bit gap,
                               input int inject_at, output bit ok);
        int i = 0;
        int k = 0;
        start = 1'b1; mode = 1'b0; base_addr = b; len_m1 = l;
        adv();
        start = 1'b0;
        hs_cyc.delete();
        while (i < d.size() && k < 200) begin
            s_valid = gap ? (k % 2 == 0) : 1'b1;
            s_data  = d[i];
            start   = (k == inject_at);
            if (start) begin
                mode = 1'b1; base_addr = 16'h9999; len_m1 = 16'h0003;
            end
            @(negedge clk);
            if (s_valid && s_ready) begin
                hs_cyc.push_back(cyc_n);
                i++;
            end
            adv();
            k++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        ok = (i == d.size());
    endtask

    task automatic wait_done(input int d0, output bit ok);
        for (int k = 0; k < 50 && done_cnt == d0; k++) adv();
        ok = (done_cnt != d0);
    endtask

    task automatic read_burst(input logic [AW-1:0] b, input logic [AW-1:0] l,
                              input bit bp, output bit ok);
        int d0 = done_cnt;
        start = 1'b1; mode = 1'b1; base_addr = b; len_m1 = l;
        adv();
        start = 1'b0;
        for (int k = 0; k < 300 && done_cnt == d0; k++) begin
            m_ready = bp ? (k % 3 == 0) : 1'b1;
            adv();
        end
        m_ready = 1'b1;
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        repeat (2) adv();
        @(negedge clk);
        n_checks++;
        if ({s_ready, m_valid, busy, done, ram_we, ram_re} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b exp 000000",
                     {s_ready, m_valid, busy, done, ram_we, ram_re});
        end
        n_checks++;
        if ({m_data, ram_din, ram_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: m_data=%h ram_din=%h ram_addr=%h exp all 0",
                     m_data, ram_din, ram_addr);
        end
        adv();
        rst = 1'b0;
        adv();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d[$];
        bit ok1, ok2;
        int w0 = we_addr_log.size();
        int r0 = rd_log.size();
        int d0 = done_cnt;
        for (int i = 0; i < 14; i++) d.push_back(24'(i * 5000));
        write_burst(16'h0000, 16'd13, d, 1'b0, -1, ok1);
        wait_done(d0, ok2);
        repeat (3) adv();
        n_checks++;
        if (!(ok1 && ok2) || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL wr14_done: done pulses %0d exp 1 (fed=%0b done_seen=%0b)",
                     done_cnt - d0, ok1, ok2);
        end
        n_checks++;
        if (we_addr_log.size() - w0 != 14) begin
            n_fail++;
            $display("FAIL wr14_count: got %0d writes exp 14", we_addr_log.size() - w0);
        end
        for (int i = 0; i < 14 && w0 + i < we_addr_log.size(); i++) begin
            n_checks++;
            if (we_addr_log[w0+i] !== 16'(i) || we_data_log[w0+i] !== 24'(i * 5000)) begin
                n_fail++;
                $display("FAIL wr14_word%0d: got %h@%h exp %h@%h", i, we_data_log[w0+i],
                         we_addr_log[w0+i], 24'(i * 5000), 16'(i));
            end
        end
        d0 = done_cnt;
        read_burst(16'h0000, 16'd13, 1'b0, ok1);
        repeat (3) adv();
        n_checks++;
        if (!ok1 || done_cnt - d0 != 1 || rd_log.size() - r0 != 14) begin
            n_fail++;
            $display("FAIL rd14_done: done pulses %0d words %0d exp 1 and 14",
                     done_cnt - d0, rd_log.size() - r0);
        end
        for (int i = 0; i < 14 && r0 + i < rd_log.size(); i++) begin
            n_checks++;
            if (rd_log[r0+i] !== 24'(i * 5000)) begin
                n_fail++;
                $display("FAIL rd14_word%0d: got %h exp %h", i, rd_log[r0+i], 24'(i * 5000));
            end
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] d[$];
        bit ok1, ok2;
        int w0 = we_addr_log.size();
        int r0 = rd_log.size();
        int e0 = re_cyc_log.size();
        int v0 = mv_cyc_log.size();
        int d0 = done_cnt;
        d.push_back(24'hABCDEF);
        write_burst(16'h1234, 16'd0, d, 1'b0, -1, ok1);
        wait_done(d0, ok2);
        repeat (2) adv();
        n_checks++;
        if (!(ok1 && ok2) || we_addr_log.size() - w0 != 1) begin
            n_fail++;
            $display("FAIL single_wr_count: got %0d writes exp 1", we_addr_log.size() - w0);
        end else begin
            n_checks++;
            if (we_addr_log[w0] !== 16'h1234 || we_data_log[w0] !== 24'hABCDEF) begin
                n_fail++;
                $display("FAIL single_wr_word: got %h@%h exp abcdef@1234",
                         we_data_log[w0], we_addr_log[w0]);
            end
            n_checks++;
            if (done_cyc - we_cyc_log[w0] != 1) begin
                n_fail++;
                $display("FAIL single_done_lat: got %0d cycles exp 1", done_cyc - we_cyc_log[w0]);
            end
        end
        read_burst(16'h1234, 16'd0, 1'b0, ok1);
        repeat (2) adv();
        n_checks++;
        if (!ok1 || rd_log.size() - r0 != 1 || rd_log[rd_log.size()-1] !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL single_rd_word: words %0d last %h exp 1 word abcdef",
                     rd_log.size() - r0, rd_log[rd_log.size()-1]);
        end
        n_checks++;
        if (re_cyc_log.size() <= e0 || mv_cyc_log.size() <= v0 ||
            mv_cyc_log[v0] - re_cyc_log[e0] != 2) begin
            n_fail++;
            $display("FAIL single_rd_lat: got %0d cycles ram_re->m_valid exp 2",
                     (mv_cyc_log.size() > v0 && re_cyc_log.size() > e0) ?
                     mv_cyc_log[v0] - re_cyc_log[e0] : -1);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int r0 = rd_log.size();
        int s0 = stall_err;
        read_burst(16'h0000, 16'd7, 1'b1, ok);
        repeat (2) adv();
        n_checks++;
        if (!ok || rd_log.size() - r0 != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words exp 8", rd_log.size() - r0);
        end
        for (int i = 0; i < 8 && r0 + i < rd_log.size(); i++) begin
            n_checks++;
            if (rd_log[r0+i] !== 24'(i * 5000)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got %h exp %h", i, rd_log[r0+i], 24'(i * 5000));
            end
        end
        n_checks++;
        if (stall_err != s0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d m_data changes during stall exp 0", stall_err - s0);
        end
        n_checks++;
        if (max_infl > 2) begin
            n_fail++;
            $display("FAIL bp_ahead: got %0d reads ahead of consumption exp <=2", max_infl);
        end
        n_checks++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL we_re_excl: got %0d cycles with both high exp 0", both_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d[$];
        logic [AW-1:0] exp_a[4];
        bit ok1, ok2;
        int w0 = we_addr_log.size();
        int e0 = re_addr_log.size();
        int r0 = rd_log.size();
        int d0 = done_cnt;
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 4; i++) d.push_back(24'((i + 1) * 24'h111111));
        write_burst(16'hFFFE, 16'd3, d, 1'b0, -1, ok1);
        wait_done(d0, ok2);
        adv();
        read_burst(16'hFFFE, 16'd3, 1'b0, ok1);
        repeat (2) adv();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (w0 + i >= we_addr_log.size() || we_addr_log[w0+i] !== exp_a[i]) begin
                n_fail++;
                $display("FAIL wrap_wr_addr%0d: got %h exp %h", i,
                         (w0 + i < we_addr_log.size()) ? we_addr_log[w0+i] : 16'hxxxx, exp_a[i]);
            end
            n_checks++;
            if (e0 + i >= re_addr_log.size() || re_addr_log[e0+i] !== exp_a[i] ||
                r0 + i >= rd_log.size() || rd_log[r0+i] !== d[i]) begin
                n_fail++;
                $display("FAIL wrap_rd%0d: exp %h from %h (reads %0d words %0d)", i, d[i],
                         exp_a[i], re_addr_log.size() - e0, rd_log.size() - r0);
            end
        end
    endtask

    task automatic test_gapped();
        logic [DW-1:0] d[$];
        bit ok1, ok2;
        int w0 = we_addr_log.size();
        int t0 = re_total;
        int d0 = done_cnt;
        for (int i = 0; i < 5; i++) d.push_back(24'(24'hA00000 + i));
        write_burst(16'h0100, 16'd4, d, 1'b1, 2, ok1);
        wait_done(d0, ok2);
        repeat (5) adv();
        n_checks++;
        if (!(ok1 && ok2) || we_addr_log.size() - w0 != 5 || hs_cyc.size() != 5) begin
            n_fail++;
            $display("FAIL gap_count: got %0d writes %0d handshakes exp 5 and 5",
                     we_addr_log.size() - w0, hs_cyc.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                n_checks++;
                if (we_cyc_log[w0+j] != hs_cyc[j] + 1 || we_addr_log[w0+j] !== 16'(16'h0100 + j) ||
                    we_data_log[w0+j] !== d[j]) begin
                    n_fail++;
                    $display("FAIL gap_write%0d: got %h@%h cyc %0d exp %h@%h cyc %0d", j,
                             we_data_log[w0+j], we_addr_log[w0+j], we_cyc_log[w0+j],
                             d[j], 16'(16'h0100 + j), hs_cyc[j] + 1);
                end
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1 || re_total != t0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_busy_start: done %0d reads %0d busy %b exp 1, 0, 0",
                     done_cnt - d0, re_total - t0, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d[$];
        bit ok1, ok2;
        int i = 0;
        int w0 = we_addr_log.size();
        int d0 = done_cnt;
        start = 1'b1; mode = 1'b0; base_addr = 16'h0200; len_m1 = 16'd9;
        adv();
        start = 1'b0;
        for (int k = 0; k < 20 && i < 3; k++) begin
            s_valid = 1'b1;
            s_data  = 24'(24'h500000 + i);
            @(negedge clk);
            if (s_ready) i++;
            adv();
        end
        s_valid = 1'b0;
        rst = 1'b1;
        adv();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ram_we, busy, s_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got we/busy/s_ready=%b exp 000", {ram_we, busy, s_ready});
        end
        repeat (10) adv();
        n_checks++;
        if (done_cnt != d0 || we_addr_log.size() - w0 != 3) begin
            n_fail++;
            $display("FAIL rstmid_abort: got %0d done %0d writes exp 0 and 3",
                     done_cnt - d0, we_addr_log.size() - w0);
        end
        w0 = we_addr_log.size();
        d.push_back(24'h0F0F0F);
        d.push_back(24'hF0F0F0);
        write_burst(16'h0300, 16'd1, d, 1'b0, -1, ok1);
        wait_done(d0, ok2);
        repeat (2) adv();
        n_checks++;
        if (!(ok1 && ok2) || done_cnt - d0 != 1 || we_addr_log.size() - w0 != 2 ||
            we_addr_log[w0] !== 16'h0300 || we_data_log[w0+1] !== 24'hF0F0F0) begin
            n_fail++;
            $display("FAIL rstmid_restart: done %0d writes %0d exp 1 and 2 at 0300/0301",
                     done_cnt - d0, we_addr_log.size() - w0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_single();
        test_backpressure();
        test_wrap();
        test_gapped();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
